seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 129 ++++++++++++
 tb/tb_seq_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// Purpose: decodes a select index into a one-hot, thermometer or timed scanning output pattern.
// Latency: out, out_valid and scan_done update 1 cycle after the accepting edge; rst clears them immediately.
// Backpressure: in_ready drops for the whole scan; in_valid seen while in_ready is low is dropped, never queued.
module seq_decoder #(
    parameter int SEL_W     = 3,
    parameter int SCAN_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [1:0]            mode,
    output logic [2**SEL_W-1:0]   out,
    output logic                  out_valid,
    output logic                  scan_done
);

    localparam int         OUT_W     = 2**SEL_W;
    localparam logic [7:0] HOLD_LAST = 8'(SCAN_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               done_q, done_d;

    logic [OUT_W-1:0]   onehot_pat;
    logic [OUT_W-1:0]   therm_pat;

    // Candidate patterns for the incoming select index.
    always_comb begin
        onehot_pat      = '0;
        onehot_pat[sel] = 1'b1;
        therm_pat       = '0;
        for (int k = 0; k < OUT_W; k++) begin
            therm_pat[k] = (k <= int'(sel));
        end
    end

    // Next-state logic: clr wins over everything, then command accept or scan advance.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (clr) begin
            state_d = IDLE;
            out_d   = '0;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (in_valid) begin
                        idx_d = sel;
                        cnt_d = '0;
                        if (mode == 2'b10) begin
                            state_d = SCAN;
                            out_d   = onehot_pat;
                        end else if (mode == 2'b01) begin
                            state_d = HOLD;
                            out_d   = therm_pat;
                        end else begin
                            // 00 and the reserved 11 both decode as one-hot.
                            state_d = HOLD;
                            out_d   = onehot_pat;
                        end
                    end
                end
                SCAN: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        if (idx_q == {SEL_W{1'b1}}) begin
                            // Last index has been held long enough: end without wrapping.
                            state_d = IDLE;
                            out_d   = '0;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            out_d = out_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and pattern registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q != SCAN);
    assign out_valid = (state_q != IDLE);
    assign out       = out_q;
    assign scan_done = done_q;

endmodule

// File: tb/tb_seq_decoder.sv
// Purpose: randomized and directed stimulus for seq_decoder, checked against a pattern-list reference model.
// Latency: expected outputs are queued at each rising edge and compared at the following falling edge.
// Backpressure: the model ignores commands while a scan is in progress, as in_ready requires.
module tb_seq_decoder;

    localparam int SEL_W = 3;
    localparam int HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] sel = '0;
    logic [1:0] mode = '0;

    logic       in_ready, out_valid, scan_done;
    logic [7:0] out;
    logic       h1_in_ready, h1_out_valid, h1_scan_done;
    logic [7:0] h1_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] out;
        logic       vld;
        logic       done;
        logic       rdy;
    } exp_t;

    exp_t expq[$];

    // Reference model: current pattern plus the list of patterns a scan still has to show.
    logic [7:0] m_out = '0;
    logic       m_vld = 1'b0;
    logic       m_done = 1'b0;
    logic       m_scan = 1'b0;
    logic [7:0] pend[$];

    seq_decoder #(.SEL_W(SEL_W), .SCAN_HOLD(HOLD)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .mode(mode), .out(out), .out_valid(out_valid), .scan_done(scan_done)
    );

    seq_decoder #(.SEL_W(SEL_W), .SCAN_HOLD(1)) dut_h1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(h1_in_ready),
        .sel(sel), .mode(mode), .out(h1_out), .out_valid(h1_out_valid), .scan_done(h1_scan_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = '0;
        m_vld  = 1'b0;
        m_done = 1'b0;
        m_scan = 1'b0;
        pend.delete();
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.out  = m_out;
        e.vld  = m_vld;
        e.done = m_done;
        e.rdy  = !m_scan;
        return e;
    endfunction

    task automatic model_edge(input logic c, input logic v, input int s, input int md);
        m_done = 1'b0;
        if (c) begin
            model_reset();
        end else if (m_scan) begin
            if (pend.size() > 0) begin
                m_out = pend.pop_front();
            end else begin
                m_out  = '0;
                m_vld  = 1'b0;
                m_scan = 1'b0;
                m_done = 1'b1;
            end
        end else if (v) begin
            m_vld = 1'b1;
            if (md == 2) begin
                for (int i = s; i < 8; i++)
                    for (int j = 0; j < HOLD; j++)
                        pend.push_back(8'(1 << i));
                m_out  = pend.pop_front();
                m_scan = 1'b1;
            end else if (md == 1) begin
                m_out = 8'((16'd2 << s) - 16'd1);
            end else begin
                m_out = 8'(1 << s);
            end
        end
    endtask

    // One clock of stimulus: drive inputs, let the edge happen, queue what must follow.
    task automatic step(input logic c, input logic v, input int s, input int md);
        #1;
        clr      = c;
        in_valid = v;
        sel      = 3'(s);
        mode     = 2'(md);
        @(posedge clk);
        model_edge(c, v, s, md);
        expq.push_back(model_now());
    endtask

    // Reset asserted between edges: outputs must clear before any clock arrives.
    task automatic async_reset();
        #2;
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b1;
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_vld", 32'(out_valid), 32'h0);
        chk("async_rst_done", 32'(scan_done), 32'h0);
        chk("async_rst_rdy", 32'(in_ready), 32'h1);
        model_reset();
        expq.delete();
        expq.push_back(model_now());
        @(posedge clk);
        expq.push_back(model_now());
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest queued expectation once per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("out", 32'(out), 32'(e.out));
                chk("out_valid", 32'(out_valid), 32'(e.vld));
                chk("scan_done", 32'(scan_done), 32'(e.done));
                chk("in_ready", 32'(in_ready), 32'(e.rdy));
            end
        end
    end

    initial begin
        // Reset state.
        #3;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_vld", 32'(out_valid), 32'h0);
        chk("rst_done", 32'(scan_done), 32'h0);
        chk("rst_rdy", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // One-hot for every select value, accepted right after reset release.
        for (int s = 0; s < 8; s++) step(1'b0, 1'b1, s, 0);

        // Thermometer 5 then 0, back to back.
        step(1'b0, 1'b1, 5, 1);
        step(1'b0, 1'b1, 0, 1);

        // Scan from 5 with random in_valid pulses that must be ignored.
        step(1'b0, 1'b1, 5, 2);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
        step(1'b0, 1'b0, 0, 0);

        // Single-step scan at index 7 on the SCAN_HOLD=1 instance.
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b1, 7, 2);
        @(negedge clk);
        chk("h1_scan7_out", 32'(h1_out), 32'h80);
        chk("h1_scan7_done", 32'(h1_scan_done), 32'h0);
        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        chk("h1_end_out", 32'(h1_out), 32'h0);
        chk("h1_end_done", 32'(h1_scan_done), 32'h1);
        chk("h1_end_vld", 32'(h1_out_valid), 32'h0);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        // clr beats in_valid in HOLD.
        step(1'b0, 1'b1, 3, 0);
        step(1'b1, 1'b1, 6, 0);
        step(1'b0, 1'b0, 0, 0);

        // clr mid-scan: no scan_done.
        step(1'b0, 1'b1, 2, 2);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);

        // Asynchronous reset mid-scan, then reserved mode decodes as one-hot.
        step(1'b0, 1'b1, 1, 2);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        async_reset();
        step(1'b0, 1'b1, 2, 3);
        step(1'b0, 1'b0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

        step(1'b0, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
